// File: rtl/alu_sequencer_if.sv
// Bundles the command, operand-bus, result and ALU-side signals of the sequencer.
// The slave modport is the sequencer; the master modport is the surrounding system plus the ALU.
interface alu_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [15:0] bus_in;
  logic        bus_valid;
  logic        bus_ready;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  flags;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_sel;
  logic        alu_oe;
  logic [15:0] alu_o;
  logic [7:0]  alu_f;

  modport master (
    output start, op, bus_in, bus_valid, alu_o, alu_f,
    input  bus_ready, busy, done, result, flags, alu_a, alu_b, alu_sel, alu_oe
  );

  modport slave (
    input  start, op, bus_in, bus_valid, alu_o, alu_f,
    output bus_ready, busy, done, result, flags, alu_a, alu_b, alu_sel, alu_oe
  );
endinterface

// File: rtl/alu_sequencer.sv
// Collects an op code and one or two bus operands, drives the combinational ALU for one
// EXEC cycle, then latches its result and flags for the downstream consumer.
module alu_sequencer (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  sif
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] alu_a_q, alu_b_q, result_q;
  logic [2:0]  alu_sel_q;
  logic [7:0]  flags_q;
  logic        bus_ready;
  logic        is_unary;
  logic        div_by_zero;

  assign is_unary    = (alu_sel_q == 3'b010) || (alu_sel_q == 3'b011);
  assign div_by_zero = (alu_sel_q == 3'b101) && (alu_b_q == 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sif.start) state_d = S_LOAD_A;
      S_LOAD_A: if (sif.bus_valid) state_d = is_unary ? S_EXEC : S_LOAD_B;
      S_LOAD_B: if (sif.bus_valid) state_d = S_EXEC;
      S_EXEC:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Every control output is a pure decode of the state register.
  always_comb begin
    bus_ready  = 1'b0;
    sif.busy   = 1'b1;
    sif.done   = 1'b0;
    sif.alu_oe = 1'b0;
    case (state_q)
      S_IDLE:   sif.busy   = 1'b0;
      S_LOAD_A: bus_ready  = 1'b1;
      S_LOAD_B: bus_ready  = 1'b1;
      S_EXEC:   sif.alu_oe = 1'b1;
      S_DONE:   sif.done   = 1'b1;
      default:  sif.busy   = 1'b0;
    endcase
  end

  assign sif.bus_ready = bus_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sif.start) alu_sel_q <= sif.op;
        end
        S_LOAD_A: begin
          if (sif.bus_valid) begin
            alu_a_q <= sif.bus_in;
            if (is_unary) alu_b_q <= '0;
          end
        end
        S_LOAD_B: begin
          if (sif.bus_valid) alu_b_q <= sif.bus_in;
        end
        S_EXEC: begin
          result_q <= sif.alu_o;
          flags_q  <= {4'b0000, sif.alu_o[15], div_by_zero, sif.alu_f[1], sif.alu_f[0]};
        end
        default: ;
      endcase
    end
  end

  assign sif.alu_a   = alu_a_q;
  assign sif.alu_b   = alu_b_q;
  assign sif.alu_sel = alu_sel_q;
  assign sif.result  = result_q;
  assign sif.flags   = flags_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 16-bit ALU in the loop.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if sif();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  typedef struct {
    logic [15:0] res;
    logic [7:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;

  function automatic logic [16:0] alu_model(logic [2:0] s, logic [15:0] a, logic [15:0] b);
    logic [31:0] p;
    case (s)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {1'b0, a} - {1'b0, b};
      3'b010:  return {1'b0, a} + 17'd1;
      3'b011:  return {1'b0, a} - 17'd1;
      3'b100:  begin p = a * b; return p[16:0]; end
      3'b101:  return (b == 16'h0) ? 17'h0 : {1'b0, a / b};
      3'b110:  return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  logic [16:0] alu_r;
  always_comb alu_r = alu_model(sif.alu_sel, sif.alu_a, sif.alu_b);
  assign sif.alu_o = alu_r[15:0];
  assign sif.alu_f = {6'b0, alu_r[16], (alu_r == 17'h0)};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sif.done) begin
      exp_t e;
      n_done++;
      check_eq("done_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("result", sif.result, e.res);
        check_eq("flags", sif.flags, e.flg);
        $display("done: result=0x%04h flags=0x%02h", sif.result, sif.flags);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall, input bit inject, input logic [15:0] exp_res,
                        input logic [7:0] exp_flg, input int exp_lat);
    int  cyc;
    bit  unary;
    exp_t e;
    unary = (op == 3'b010) || (op == 3'b011);
    e.res = exp_res;
    e.flg = exp_flg;
    sb_q.push_back(e);
    $display("issue: op=%0d a=0x%04h b=0x%04h stall=%0d", op, a, b, stall);
    sif.start = 1'b1;
    sif.op    = op;
    @(negedge clk);
    cyc = 1;
    sif.start     = 1'b0;
    sif.bus_valid = 1'b0;
    check_eq("ready_load_a", sif.bus_ready, 1);
    repeat (stall) begin
      @(negedge clk);
      cyc++;
    end
    sif.bus_valid = 1'b1;
    sif.bus_in    = a;
    @(negedge clk);
    cyc++;
    if (!unary) begin
      sif.bus_in = b;
      if (inject) begin
        sif.start = 1'b1;
        sif.op    = 3'b110;
      end
      @(negedge clk);
      cyc++;
      sif.start = 1'b0;
    end
    sif.bus_valid = 1'b0;
    check_eq("alu_oe_exec", sif.alu_oe, 1);
    check_eq("ready_exec", sif.bus_ready, 0);
    while (!sif.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", cyc, exp_lat);
    @(negedge clk);
    check_eq("idle_after_done", {sif.busy, sif.done}, 2'b00);
  endtask

  function automatic logic [7:0] model_flags(logic [2:0] s, logic [15:0] b, logic [16:0] r);
    return {4'b0, r[15], (s == 3'b101 && b == 16'h0), r[16], (r == 17'h0)};
  endfunction

  initial begin
    sif.start     = 1'b0;
    sif.op        = 3'b000;
    sif.bus_in    = 16'h0;
    sif.bus_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_ctrl", {sif.busy, sif.done, sif.bus_ready, sif.alu_oe}, 4'b0000);
    check_eq("rst_data", {sif.result, sif.flags}, 24'h0);
    check_eq("rst_alu", {sif.alu_a, sif.alu_b, 13'h0, sif.alu_sel}, 48'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'b000, 16'hFFFF, 16'h0001, 0, 1'b0, 16'h0000, 8'h02, 4);
    run_op(3'b001, 16'h0003, 16'h0005, 0, 1'b0, 16'hFFFE, 8'h0A, 4);
    run_op(3'b010, 16'hFFFF, 16'h1234, 3, 1'b0, 16'h0000, 8'h02, 6);
    check_eq("alu_b_unary", sif.alu_b, 16'h0000);
    run_op(3'b101, 16'h0007, 16'h0000, 0, 1'b0, 16'h0000, 8'h05, 4);
    run_op(3'b101, 16'd100,  16'd7,    0, 1'b0, 16'h000E, 8'h00, 4);

    run_op(3'b111, 16'h00F0, 16'h0F00, 0, 1'b1, 16'h0FF0, 8'h00, 4);
    check_eq("alu_sel_held", sif.alu_sel, 3'b111);
    repeat (8) @(negedge clk);
    check_eq("single_done_idle", sif.busy, 0);

    // Reset asserted in the middle of EXEC; nothing is pushed, so any done fails.
    sif.start = 1'b1;
    sif.op    = 3'b000;
    @(negedge clk);
    sif.start     = 1'b0;
    sif.bus_valid = 1'b1;
    sif.bus_in    = 16'h1234;
    @(negedge clk);
    sif.bus_in = 16'h0001;
    @(negedge clk);
    sif.bus_valid = 1'b0;
    check_eq("pre_reset_exec", sif.alu_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_ctrl", {sif.busy, sif.done, sif.bus_ready, sif.alu_oe}, 4'b0000);
    check_eq("midrst_data", {sif.result, sif.flags}, 24'h0);
    check_eq("midrst_alu", {sif.alu_a, sif.alu_b, 13'h0, sif.alu_sel}, 48'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'b000, 16'h1234, 16'h0001, 0, 1'b0, 16'h1235, 8'h00, 4);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  s;
      logic [15:0] a, b;
      logic [16:0] r;
      int          st;
      s  = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = (i == 0) ? 16'h0 : 16'($urandom);
      st = $urandom_range(0, 2);
      if (s == 3'b010 || s == 3'b011) begin
        r = alu_model(s, a, 16'h0);
        run_op(s, a, b, st, 1'b0, r[15:0], model_flags(s, 16'h0, r), 3 + st);
      end else begin
        r = alu_model(s, a, b);
        run_op(s, a, b, st, 1'b0, r[15:0], model_flags(s, b, r), 4 + st);
      end
    end

    repeat (4) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("done_count", n_done, 15);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencing controller directly upstream of the 16-bit ALU. It accepts an operation command from the control unit and collects one or two 16-bit operands from the shared data bus through a valid/ready handshake. It presents the registered operands and select to the ALU for one execute cycle, then latches the ALU result and flags into holding registers for the downstream consumer. It owns all ALU inputs; the ALU remains purely combinational.

## Interface
- (no parameters; data width fixed at 16, flag width fixed at 8)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- op  in  3  ALU operation code (000 add, 001 sub, 010 inc, 011 dec, 100 mul, 101 div, 110 and, 111 or); captured with start
- bus_in  in  16  operand data from shared bus
- bus_valid  in  1  bus_in holds a valid operand
- bus_ready  out  1  sequencer will accept an operand this cycle
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse: result/flags updated
- result  out  16  latched ALU result, held until next done
- flags  out  8  latched flags, held until next done
- alu_a  out  16  operand A to ALU (registered)
- alu_b  out  16  operand B to ALU (registered)
- alu_sel  out  3  operation select to ALU (registered)
- alu_oe  out  1  ALU output enable; high only in EXEC
- alu_o  in  16  ALU result (combinational)
- alu_f  in  8  ALU flags; bit0 zero (17-bit result == 0), bit1 carry/bit16

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, DONE.
- IDLE: if start, capture op into alu_sel, go LOAD_A. Otherwise remain.
- LOAD_A: bus_ready=1. On bus_valid&&bus_ready, alu_a<=bus_in. Unary op (010, 011): alu_b<=0, go EXEC. Otherwise go LOAD_B. Without bus_valid, wait indefinitely.
- LOAD_B: bus_ready=1. On handshake, alu_b<=bus_in, go EXEC.
- EXEC: alu_oe=1. At the closing edge: result<=alu_o, and flags are loaded as follows. flags[0]<=alu_f[0], flags[1]<=alu_f[1], flags[2]<=(alu_sel==101 && alu_b==0), flags[3]<=alu_o[15], flags[7:4]<=0. Go DONE.
- DONE: done=1 for exactly this cycle, go IDLE.
- start asserted while busy: ignored, not queued. op is not re-sampled.
- bus_ready is low in IDLE, EXEC and DONE. bus_valid there is ignored.
- alu_a, alu_b and alu_sel hold their values after DONE until the next capture.
- Reset (asynchronous, any state including mid-operation): state IDLE. busy, done, bus_ready and alu_oe = 0. result, flags, alu_a, alu_b and alu_sel = 0. No partial result is ever published.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from bus_in, bus_valid or start to any output.
- Binary op, with bus_valid held high: start sampled at edge 0 → LOAD_A cycle 1 → LOAD_B cycle 2 → EXEC cycle 3 → DONE cycle 4 (done high) → IDLE cycle 5. Latency from start edge to done is 4 cycles.
- Unary op: LOAD_A → EXEC → DONE. done is high in cycle 3.
- Each stall cycle on bus_valid adds exactly one cycle.
- Back-to-back: start may be reasserted in the IDLE cycle after DONE. The minimum issue interval is 5 cycles for binary ops and 4 for unary ops.
- alu_a, alu_b and alu_sel are stable for the whole EXEC cycle. The ALU has one full cycle of combinational settle.
- result and flags change only at the edge entering DONE.

## Test plan
- Add overflow: op=000, A=0xFFFF, B=0x0001 → done in cycle 4, result=0x0000, flags=0x02 (carry, 17-bit zero flag clear).
- Subtract borrow: op=001, A=0x0003, B=0x0005 → result=0xFFFE, flags=0x0A (carry + sign).
- Unary increment with stalls: op=010, A=0xFFFF, bus_valid withheld 3 cycles → no LOAD_B and bus_ready drops after A. done arrives 3+3 cycles after start. result=0x0000, flags=0x02, alu_b=0.
- Divide by zero: op=101, A=0x0007, B=0x0000 → result=0x0000, flags=0x05 (zero + divzero). Then op=101, A=100, B=7 → result=0x000E, flags=0x00.
- Ignored start: pulse start with op=110 during LOAD_B of an op=111 (A=0x00F0, B=0x0F00) → single done, result=0x0FF0, alu_sel=111.
- Reset mid-op: rst_n low asynchronously during EXEC → all outputs 0 immediately, no done pulse. The next command completes normally.
